// File: rtl/opb_simulink_master.sv
// OPB initiator for fabric-side register access: one single-beat read or write in flight,
// arbitrated as a second bus master, completed with read data and a 2-bit status.
module opb_simulink_master #(
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_TIMEOUT    = 16,
    parameter int unsigned C_MAX_RETRY  = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]   cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1] cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]   cmd_wdata,
    output logic                      rsp_valid,
    output logic [0:C_OPB_DWIDTH-1]   rsp_data,
    output logic [1:0]                rsp_err,
    output logic                      M_request,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_busLock,
    output logic                      M_seqAddr,
    input  logic                      OPB_MGrant,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

    localparam logic [4:0] LP_MAX_RETRY = 5'(C_MAX_RETRY);
    localparam logic [7:0] LP_TIMEOUT   = 8'(C_TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SLAVE   = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StResp} state_e;

    state_e                    r_state, w_state_d;
    logic                      r_rnw;
    logic [0:C_OPB_AWIDTH-1]   r_addr;
    logic [0:C_OPB_DWIDTH/8-1] r_be;
    logic [0:C_OPB_DWIDTH-1]   r_wdata;
    logic [4:0]                r_retry, w_retry_d, w_retry_inc;
    logic [7:0]                r_tout, w_tout_d, w_tout_inc;
    logic [0:C_OPB_DWIDTH-1]   r_rsp_data, w_rsp_data_d;
    logic [1:0]                r_rsp_err, w_rsp_err_d;
    logic                      w_accept;

    assign w_accept    = cmd_valid && (r_state == StIdle);
    assign w_retry_inc = r_retry + 5'd1;
    assign w_tout_inc  = r_tout + 8'd1;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state    <= StIdle;
            r_retry    <= '0;
            r_tout     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= ERR_OK;
        end else begin
            r_state    <= w_state_d;
            r_retry    <= w_retry_d;
            r_tout     <= w_tout_d;
            r_rsp_data <= w_rsp_data_d;
            r_rsp_err  <= w_rsp_err_d;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rnw   <= cmd_rnw;
            r_addr  <= cmd_addr;
            r_be    <= cmd_be;
            r_wdata <= cmd_wdata;
        end
    end

    // XFER resolution order: xferAck, errAck, retry, then timeout.
    always_comb begin
        w_state_d    = r_state;
        w_retry_d    = r_retry;
        w_tout_d     = r_tout;
        w_rsp_data_d = r_rsp_data;
        w_rsp_err_d  = r_rsp_err;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_state_d = StReq;
                    w_retry_d = '0;
                end
            end
            StReq: begin
                w_tout_d = '0;
                if (OPB_MGrant) begin
                    w_state_d = StXfer;
                end
            end
            StXfer: begin
                if (OPB_xferAck) begin
                    w_state_d    = StResp;
                    w_rsp_data_d = r_rnw ? OPB_DBus : '0;
                    w_rsp_err_d  = OPB_errAck ? ERR_SLAVE : ERR_OK;
                end else if (OPB_errAck) begin
                    w_state_d    = StResp;
                    w_rsp_data_d = '0;
                    w_rsp_err_d  = ERR_SLAVE;
                end else if (OPB_retry) begin
                    w_retry_d = w_retry_inc;
                    if (w_retry_inc > LP_MAX_RETRY) begin
                        w_state_d    = StResp;
                        w_rsp_data_d = '0;
                        w_rsp_err_d  = ERR_RETRY;
                    end else begin
                        w_state_d = StReq;
                    end
                end else if (!OPB_toutSup) begin
                    w_tout_d = w_tout_inc;
                    if (w_tout_inc == LP_TIMEOUT) begin
                        w_state_d    = StResp;
                        w_rsp_data_d = '0;
                        w_rsp_err_d  = ERR_TIMEOUT;
                    end
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs decode only registered state, so the OR-bus sees zeros outside XFER.
    always_comb begin
        cmd_ready = (r_state == StIdle);
        rsp_valid = (r_state == StResp);
        rsp_data  = r_rsp_data;
        rsp_err   = r_rsp_err;
        M_request = (r_state == StReq);
        M_select  = (r_state == StXfer);
        M_RNW     = 1'b0;
        M_ABus    = '0;
        M_BE      = '0;
        M_DBus    = '0;
        M_busLock = 1'b0;
        M_seqAddr = 1'b0;
        if (r_state == StXfer) begin
            M_RNW  = r_rnw;
            M_ABus = r_addr;
            M_BE   = r_be;
            M_DBus = r_rnw ? '0 : r_wdata;
        end
    end

endmodule

// File: doc/opb_simulink_master.md
# opb_simulink_master

OPB bus initiator driven from Simulink user logic: accepts one single-beat read or write command at a time, arbitrates for the OPB, runs the transfer against any `opb_register_*` style slave and returns data plus a completion status. It sits beside the PPC on the ROACH2 OPB as a second master. Fabric logic can then poll or configure slave registers, such as the FFT overflow status registers, without software involvement.

## Interface
Parameters:
- C_OPB_AWIDTH, 32: address bus width.
- C_OPB_DWIDTH, 32: data bus width.
- C_TIMEOUT, 16: XFER cycles without acknowledge before a timeout; range 2..255.
- C_MAX_RETRY, 4: OPB_retry events tolerated before the command is abandoned; range 0..15.

Ports:
- OPB_Clk  in  1  the single clock; bus side and user side both run on it.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master idle, command accepted when valid&ready.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [0:31]  byte address.
- cmd_be  in  [0:3]  byte enables.
- cmd_wdata  in  [0:31]  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  [0:31]  read data; 0 for writes and errors.
- rsp_err  out  2  0 ok, 1 slave errAck, 2 retry limit, 3 timeout.
- M_request  out  1  bus request.
- M_select  out  1  transfer in progress.
- M_RNW  out  1  direction.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_busLock, M_seqAddr  out  1 each  tied 0.
- OPB_MGrant  in  1  grant.
- OPB_xferAck  in  1  slave acknowledge.
- OPB_errAck  in  1  slave error.
- OPB_retry  in  1  slave retry.
- OPB_toutSup  in  1  timeout suppress.
- OPB_DBus  in  [0:31]  read data.

## Operation
- States: IDLE, REQ, XFER, RESP. Reset enters IDLE.
- IDLE: cmd_ready=1.
  - valid&ready registers rnw/addr/be/wdata.
  - Clears the retry counter.
  - Next state REQ.
- REQ: M_request=1.
  - OPB_MGrant high while in REQ → XFER.
  - Timeout counter cleared.
- XFER: M_request=0, M_select=1; M_RNW, M_ABus and M_BE driven from the latched command.
  - M_DBus = wdata on writes, 0 on reads.
  - Whenever M_select=0, M_ABus, M_BE, M_DBus and M_RNW are all 0, as the OR-bus requires.
- XFER resolution, per cycle, in priority order:
  1. OPB_xferAck=1 → RESP. Read: capture OPB_DBus into rsp_data. rsp_err=1 if OPB_errAck is high in the same cycle, else 0.
  2. OPB_errAck alone → RESP, rsp_err=1, rsp_data=0.
  3. OPB_retry → retry counter +1. If the count after increment exceeds C_MAX_RETRY → RESP with rsp_err=2; otherwise → REQ.
  4. Otherwise the timeout counter increments, but only while OPB_toutSup=0; it holds while OPB_toutSup=1. Reaching C_TIMEOUT → RESP with rsp_err=3.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure. rsp_data and rsp_err hold until the next RESP.
- Commands presented while cmd_ready=0 are ignored and not queued.
- Async reset mid-transfer: all outputs go to 0 immediately (cmd_ready to 1) and the state returns to IDLE. The in-flight command is lost and no rsp_valid is produced.

## Timing
- Reset values:
  - cmd_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - All M_* outputs 0.
- Accept at cycle T → M_request high at T+1.
- Grant sampled at cycle G → M_select high at G+1.
- xferAck sampled at cycle A → M_select low at A+1, rsp_valid at A+1, cmd_ready high at A+2.
- Minimum command-to-response time, with grant at T+1 and ack in the first XFER cycle: accept at T, rsp_valid at T+3, next accept at T+4.
- Retry: M_select drops the next cycle and M_request is reasserted in that same cycle.
- All outputs are registered; there are no combinational paths from OPB inputs to outputs.

## Test plan
- Write: addr 0x01188600, data 0xDEADBEEF, be 0xF, grant after 2 cycles, ack on the 1st XFER cycle → bus carries that addr/data with M_RNW=0; rsp_valid 1 cycle, rsp_err=0, rsp_data=0.
- Read: slave returns 0x00000005 with ack on the 3rd XFER cycle → rsp_data=0x5, rsp_err=0; M_DBus=0 throughout.
- Retry with C_MAX_RETRY=4: retry on each of the first 2 attempts, ack on the 3rd → M_request asserted 3 times, rsp_err=0. Retry on every attempt → 5 grants issued, then rsp_err=2.
- Timeout with C_TIMEOUT=16: no ack, OPB_toutSup=0 → rsp_err=3 sixteen cycles after M_select rises. Repeat with OPB_toutSup=1 for 40 cycles, then ack → rsp_err=0.
- errAck together with xferAck on a read → rsp_err=1 and the data is captured. errAck alone → rsp_err=1, rsp_data=0.
- Assert OPB_Rst_n low during XFER → M_select and M_request are 0 asynchronously and no rsp_valid. After release, a new command completes normally.
